// File: rtl/mips_core_ctrl.sv
// ============================================================================
// mips_core_ctrl
// ----------------------------------------------------------------------------
// Single-cycle MIPS control/execute core. It holds the instruction decoder,
// the 32-bit ALU and the word-addressed program counter. The register file,
// instruction ROM and data RAM are external. This block only drives their
// indices, addresses and enables. The PC is the only state element, and
// everything else is combinational from the current instruction and the
// read data.
//
// Parameters
//   PC_RESET  PC value (word address) loaded on reset
//   DM_AW     data-memory word-address width; dm_addr = alu_result[DM_AW+1:2]
//
// Optional feature macro
//   SHIFTV_EN  when defined, decodes sllv/srlv/srav (funct 04/06/07) with the
//              shift amount taken from rs (read port 1) and the shifted value
//              from rt (read port 2). When undefined, those functs are NOPs.
//
// Ports
//   clk           in   rising-edge clock
//   clr_n         in   synchronous active-low reset
//   instr         in   instruction fetched at pc
//   reg_rd1_data  in   regfile read port 1 data
//   reg_rd2_data  in   regfile read port 2 data
//   dm_rd_data    in   data-memory read data
//   pc            out  current PC (word address)
//   reg_rd1_num   out  read port 1 index (rs, or rt for sll/srl/sra)
//   reg_rd2_num   out  read port 2 index (rt)
//   reg_wr_num    out  write index (rd / rt / 31)
//   reg_wr_data   out  ALU result, memory read data, or pc+1 link value
//   reg_wr_en     out  regfile write enable
//   alu_result    out  ALU result
//   alu_zero      out  alu_result == 0
//   dm_addr       out  data-memory word address
//   dm_wr_data    out  data-memory write data (rt)
//   dm_cs         out  data-memory select (lw/sw)
//   dm_rd         out  1 = read (lw), 0 = write (sw)
// ============================================================================
module mips_core_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int          DM_AW    = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [31:0]      instr,
    input  logic [31:0]      reg_rd1_data,
    input  logic [31:0]      reg_rd2_data,
    input  logic [31:0]      dm_rd_data,
    output logic [31:0]      pc,
    output logic [4:0]       reg_rd1_num,
    output logic [4:0]       reg_rd2_num,
    output logic [4:0]       reg_wr_num,
    output logic [31:0]      reg_wr_data,
    output logic             reg_wr_en,
    output logic [31:0]      alu_result,
    output logic             alu_zero,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wr_data,
    output logic             dm_cs,
    output logic             dm_rd
);

`ifdef SHIFTV_EN
    localparam bit SHIFTV_ON = 1'b1;
`else
    localparam bit SHIFTV_ON = 1'b0;
`endif

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef enum logic [1:0] {B_REG, B_IMM, B_SHAMT, B_RS_AMT} b_sel_t;
    typedef enum logic [1:0] {WR_ALU, WR_MEM, WR_LINK} wr_src_t;
    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} wr_dst_t;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    assign target = instr[25:0];

    // Decoded controls
    alu_op_t alu_op;
    b_sel_t  b_sel;
    wr_src_t wr_src;
    wr_dst_t wr_dst;
    logic    imm_zext;
    logic    rd1_is_rt;
    logic    a_is_rd2;
    logic    wr_en_d;
    logic    cs_d;
    logic    rd_d;
    logic    br_eq;
    logic    br_ne;
    logic    jmp_abs;
    logic    jmp_reg;

    // Datapath nets
    logic [31:0] imm_ext;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] pc_plus1;
    logic [31:0] br_target;
    logic [31:0] next_pc;
    logic        br_taken;

    // Instruction decoder. Anything not listed falls through to the defaults,
    // which describe a NOP: no register write, no memory access, pc+1.
    always_comb begin
        alu_op    = ALU_ADD;
        b_sel     = B_REG;
        wr_src    = WR_ALU;
        wr_dst    = DST_RD;
        imm_zext  = 1'b0;
        rd1_is_rt = 1'b0;
        a_is_rd2  = 1'b0;
        wr_en_d   = 1'b0;
        cs_d      = 1'b0;
        rd_d      = 1'b0;
        br_eq     = 1'b0;
        br_ne     = 1'b0;
        jmp_abs   = 1'b0;
        jmp_reg   = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: begin alu_op = ALU_ADD;  wr_en_d = 1'b1; end
                    FN_SUB, FN_SUBU: begin alu_op = ALU_SUB;  wr_en_d = 1'b1; end
                    FN_AND:          begin alu_op = ALU_AND;  wr_en_d = 1'b1; end
                    FN_OR:           begin alu_op = ALU_OR;   wr_en_d = 1'b1; end
                    FN_XOR:          begin alu_op = ALU_XOR;  wr_en_d = 1'b1; end
                    FN_NOR:          begin alu_op = ALU_NOR;  wr_en_d = 1'b1; end
                    FN_SLT:          begin alu_op = ALU_SLT;  wr_en_d = 1'b1; end
                    FN_SLTU:         begin alu_op = ALU_SLTU; wr_en_d = 1'b1; end
                    // Constant shifts read rt through port 1 so that port 1
                    // always feeds the ALU "a" operand.
                    FN_SLL, FN_SRL, FN_SRA: begin
                        alu_op    = (funct == FN_SLL) ? ALU_SLL :
                                    (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                        b_sel     = B_SHAMT;
                        rd1_is_rt = 1'b1;
                        wr_en_d   = 1'b1;
                    end
                    // Variable shifts keep rs on port 1 (the amount) and
                    // take the shifted value from rt on port 2.
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        if (SHIFTV_ON) begin
                            alu_op   = (funct == FN_SLLV) ? ALU_SLL :
                                       (funct == FN_SRLV) ? ALU_SRL : ALU_SRA;
                            b_sel    = B_RS_AMT;
                            a_is_rd2 = 1'b1;
                            wr_en_d  = 1'b1;
                        end
                    end
                    FN_JR: begin
                        jmp_reg = 1'b1;
                    end
                    FN_JALR: begin
                        jmp_reg = 1'b1;
                        wr_src  = WR_LINK;
                        wr_en_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_op = ALU_ADD; b_sel = B_IMM; wr_dst = DST_RT; wr_en_d = 1'b1;
            end
            OP_SLTI: begin
                alu_op = ALU_SLT; b_sel = B_IMM; wr_dst = DST_RT; wr_en_d = 1'b1;
            end
            OP_SLTIU: begin
                alu_op = ALU_SLTU; b_sel = B_IMM; wr_dst = DST_RT; wr_en_d = 1'b1;
            end
            OP_ANDI: begin
                alu_op = ALU_AND; b_sel = B_IMM; imm_zext = 1'b1;
                wr_dst = DST_RT;  wr_en_d = 1'b1;
            end
            OP_ORI: begin
                alu_op = ALU_OR;  b_sel = B_IMM; imm_zext = 1'b1;
                wr_dst = DST_RT;  wr_en_d = 1'b1;
            end
            OP_XORI: begin
                alu_op = ALU_XOR; b_sel = B_IMM; imm_zext = 1'b1;
                wr_dst = DST_RT;  wr_en_d = 1'b1;
            end
            OP_LUI: begin
                alu_op = ALU_LUI; b_sel = B_IMM; imm_zext = 1'b1;
                wr_dst = DST_RT;  wr_en_d = 1'b1;
            end
            OP_LW: begin
                alu_op = ALU_ADD; b_sel = B_IMM; wr_dst = DST_RT;
                wr_src = WR_MEM;  wr_en_d = 1'b1; cs_d = 1'b1; rd_d = 1'b1;
            end
            OP_SW: begin
                alu_op = ALU_ADD; b_sel = B_IMM; cs_d = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB; br_eq = 1'b1;
            end
            OP_BNE: begin
                alu_op = ALU_SUB; br_ne = 1'b1;
            end
            OP_J: begin
                jmp_abs = 1'b1;
            end
            OP_JAL: begin
                jmp_abs = 1'b1; wr_src = WR_LINK; wr_dst = DST_RA; wr_en_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign imm_ext = imm_zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};

    // Operand selection for the ALU.
    always_comb begin
        alu_a = a_is_rd2 ? reg_rd2_data : reg_rd1_data;
        case (b_sel)
            B_IMM:    alu_b = imm_ext;
            B_SHAMT:  alu_b = {27'h0, shamt};
            B_RS_AMT: alu_b = {27'h0, reg_rd1_data[4:0]};
            default:  alu_b = reg_rd2_data;
        endcase
    end

    // ALU. add/sub never trap, so the signed and unsigned forms share a path.
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_NOR:  alu_result = ~(alu_a | alu_b);
            ALU_SLT:  alu_result = {31'h0, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_result = {31'h0, (alu_a < alu_b)};
            ALU_SLL:  alu_result = alu_a << alu_b[4:0];
            ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_LUI:  alu_result = {alu_b[15:0], 16'h0};
            default:  alu_result = 32'h0;
        endcase
    end

    assign alu_zero = (alu_result == 32'h0);

    // Register file and data-memory side. Enables are forced low while reset
    // is asserted, so no stray write happens during reset.
    assign reg_rd1_num = rd1_is_rt ? rt : rs;
    assign reg_rd2_num = rt;
    assign reg_wr_en   = clr_n & wr_en_d;
    assign dm_cs       = clr_n & cs_d;
    assign dm_rd       = rd_d;
    assign dm_addr     = alu_result[DM_AW+1:2];
    assign dm_wr_data  = reg_rd2_data;

    always_comb begin
        case (wr_dst)
            DST_RT:  reg_wr_num = rt;
            DST_RA:  reg_wr_num = 5'd31;
            default: reg_wr_num = rd;
        endcase
        case (wr_src)
            WR_MEM:  reg_wr_data = dm_rd_data;
            WR_LINK: reg_wr_data = pc_plus1;
            default: reg_wr_data = alu_result;
        endcase
    end

    // Next-PC selection. Branches reuse the ALU subtract and test alu_zero.
    // Jumps keep the top six bits of pc+1, because the PC is a word address.
    assign pc_plus1  = pc + 32'd1;
    assign br_target = pc_plus1 + {{16{imm16[15]}}, imm16};
    assign br_taken  = (br_eq & alu_zero) | (br_ne & ~alu_zero);

    always_comb begin
        if (jmp_reg)
            next_pc = reg_rd1_data;
        else if (jmp_abs)
            next_pc = {pc_plus1[31:26], target};
        else if (br_taken)
            next_pc = br_target;
        else
            next_pc = pc_plus1;
    end

    // Program counter, the only state in the core.
    always_ff @(posedge clk) begin
        if (!clr_n)
            pc <= PC_RESET;
        else
            pc <= next_pc;
    end

endmodule

// File: tb/tb_mips_core_ctrl.sv
// ============================================================================
// tb_mips_core_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for mips_core_ctrl. Each stimulus row carries an
// instruction, the regfile/memory read data, and hand-computed expectations.
// The expectations are queued when the row is driven and popped when the
// combinational outputs and the next PC are sampled.
// ============================================================================
module tb_mips_core_ctrl;

    logic        clk;
    logic        clr_n;
    logic [31:0] instr;
    logic [31:0] reg_rd1_data;
    logic [31:0] reg_rd2_data;
    logic [31:0] dm_rd_data;
    logic [31:0] pc;
    logic [4:0]  reg_rd1_num;
    logic [4:0]  reg_rd2_num;
    logic [4:0]  reg_wr_num;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wr_data;
    logic        dm_cs;
    logic        dm_rd;

    int checkCount = 0;
    int passCount  = 0;

    mips_core_ctrl #(.PC_RESET(32'h0), .DM_AW(8)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .instr        (instr),
        .reg_rd1_data (reg_rd1_data),
        .reg_rd2_data (reg_rd2_data),
        .dm_rd_data   (dm_rd_data),
        .pc           (pc),
        .reg_rd1_num  (reg_rd1_num),
        .reg_rd2_num  (reg_rd2_num),
        .reg_wr_num   (reg_wr_num),
        .reg_wr_data  (reg_wr_data),
        .reg_wr_en    (reg_wr_en),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .dm_addr      (dm_addr),
        .dm_wr_data   (dm_wr_data),
        .dm_cs        (dm_cs),
        .dm_rd        (dm_rd)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] dmrd;
        bit          chkAlu;
        logic [31:0] alu;
        bit          wrEn;
        logic [4:0]  wrNum;
        logic [31:0] wrData;
        bit          cs;
        bit          rdFlag;
        bit          chkAddr;
        logic [7:0]  addr;
        logic [4:0]  rd1Num;
        logic [31:0] nextPc;
    } row_t;

    row_t stimQ[$];
    row_t expQ[$];

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        if (obs === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic addRow(input string tag, input logic [31:0] ins,
                          input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] dmrd, input bit chkAlu,
                          input logic [31:0] alu, input bit wrEn,
                          input logic [4:0] wrNum, input logic [31:0] wrData,
                          input bit cs, input bit rdFlag, input bit chkAddr,
                          input logic [7:0] addr, input logic [4:0] rd1Num,
                          input logic [31:0] nextPc);
        row_t r;
        r.tag = tag; r.instr = ins; r.rd1 = rd1; r.rd2 = rd2; r.dmrd = dmrd;
        r.chkAlu = chkAlu; r.alu = alu; r.wrEn = wrEn; r.wrNum = wrNum;
        r.wrData = wrData; r.cs = cs; r.rdFlag = rdFlag; r.chkAddr = chkAddr;
        r.addr = addr; r.rd1Num = rd1Num; r.nextPc = nextPc;
        stimQ.push_back(r);
    endtask

    // Drive one row and queue its expectations for the checker.
    task automatic applyStimulus(input row_t r);
        instr        = r.instr;
        reg_rd1_data = r.rd1;
        reg_rd2_data = r.rd2;
        dm_rd_data   = r.dmrd;
        expQ.push_back(r);
    endtask

    // Pop the oldest expectation, compare the combinational outputs, then
    // let one clock edge pass and compare the resulting PC.
    task automatic compareRecord();
        row_t e;
        e = expQ.pop_front();
        checkOutput({e.tag, ".rd1_num"}, {27'h0, reg_rd1_num}, {27'h0, e.rd1Num});
        checkOutput({e.tag, ".wr_en"}, {31'h0, reg_wr_en}, {31'h0, e.wrEn});
        checkOutput({e.tag, ".dm_cs"}, {31'h0, dm_cs}, {31'h0, e.cs});
        if (e.chkAlu) begin
            checkOutput({e.tag, ".alu"}, alu_result, e.alu);
            checkOutput({e.tag, ".zero"}, {31'h0, alu_zero}, {31'h0, (e.alu == 32'h0)});
        end
        if (e.wrEn) begin
            checkOutput({e.tag, ".wr_num"}, {27'h0, reg_wr_num}, {27'h0, e.wrNum});
            checkOutput({e.tag, ".wr_data"}, reg_wr_data, e.wrData);
        end
        if (e.cs) begin
            checkOutput({e.tag, ".dm_rd"}, {31'h0, dm_rd}, {31'h0, e.rdFlag});
            if (!e.rdFlag)
                checkOutput({e.tag, ".dm_wr_data"}, dm_wr_data, e.rd2);
        end
        if (e.chkAddr)
            checkOutput({e.tag, ".dm_addr"}, {24'h0, dm_addr}, {24'h0, e.addr});
        @(posedge clk);
        #1;
        checkOutput({e.tag, ".next_pc"}, pc, e.nextPc);
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    localparam logic [31:0] NOP = 32'hFC000000;

    initial begin
        row_t r;

        // Reset with a lw on the bus: writes and memory select stay gated.
        clr_n        = 1'b0;
        instr        = encI(6'h23, 5'd3, 5'd5, 16'h0004);
        reg_rd1_data = 32'h100;
        reg_rd2_data = 32'h0;
        dm_rd_data   = 32'h0;
        #2;
        checkOutput("reset.wr_en", {31'h0, reg_wr_en}, 32'h0);
        checkOutput("reset.dm_cs", {31'h0, dm_cs}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset.pc", pc, 32'h0);
        clr_n = 1'b1;

        //      tag        instr                                rd1           rd2           dmrd          chkA alu           wrEn wrNum  wrData        cs rd chkAd addr   rd1N  nextPc
        addRow("nop0",     NOP,                                 32'h0,        32'h0,        32'h0,        0,   32'h0,        0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd0, 32'h1);
        addRow("nop1",     NOP,                                 32'h0,        32'h0,        32'h0,        0,   32'h0,        0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd0, 32'h2);
        addRow("addi",     encI(6'h08, 5'd1, 5'd2, 16'hFFFF),   32'h5,        32'h0,        32'h0,        1,   32'h4,        1,   5'd2,  32'h4,        0, 0, 0,    8'h00, 5'd1, 32'h3);
        addRow("beq_t",    encI(6'h04, 5'd1, 5'd2, 16'hFFFE),   32'h7,        32'h7,        32'h0,        1,   32'h0,        0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd1, 32'h2);
        addRow("nop2",     NOP,                                 32'h0,        32'h0,        32'h0,        0,   32'h0,        0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd0, 32'h3);
        addRow("beq_nt",   encI(6'h04, 5'd1, 5'd2, 16'hFFFE),   32'h7,        32'h9,        32'h0,        1,   32'hFFFFFFFE, 0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd1, 32'h4);
        addRow("sw",       encI(6'h2B, 5'd3, 5'd4, 16'h0008),   32'h100,      32'hCAFEF00D, 32'h0,        1,   32'h108,      0,   5'd0,  32'h0,        1, 0, 1,    8'h42, 5'd3, 32'h5);
        addRow("lw",       encI(6'h23, 5'd3, 5'd5, 16'h0004),   32'h100,      32'h0,        32'hDEADBEEF, 1,   32'h104,      1,   5'd5,  32'hDEADBEEF, 1, 1, 1,    8'h41, 5'd3, 32'h6);
        addRow("sra",      encR(5'd0, 5'd7, 5'd6, 5'd4, 6'h03), 32'h80000000, 32'h0,        32'h0,        1,   32'hF8000000, 1,   5'd6,  32'hF8000000, 0, 0, 0,    8'h00, 5'd7, 32'h7);
        addRow("jal",      32'h0C000010,                        32'h0,        32'h0,        32'h0,        0,   32'h0,        1,   5'd31, 32'h8,        0, 0, 0,    8'h00, 5'd0, 32'h10);
        addRow("slt",      encR(5'd1, 5'd2, 5'd8, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'h1,        32'h0,        1,   32'h1,        1,   5'd8,  32'h1,        0, 0, 0,    8'h00, 5'd1, 32'h11);
        addRow("sltu",     encR(5'd1, 5'd2, 5'd8, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'h1,        32'h0,        1,   32'h0,        1,   5'd8,  32'h0,        0, 0, 0,    8'h00, 5'd1, 32'h12);
        addRow("jr",       encR(5'd9, 5'd0, 5'd0, 5'd0, 6'h08), 32'h40,       32'h0,        32'h0,        0,   32'h0,        0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd9, 32'h40);
        addRow("jalr",     encR(5'd9, 5'd0, 5'd10, 5'd0, 6'h09),32'h20,       32'h0,        32'h0,        0,   32'h0,        1,   5'd10, 32'h41,       0, 0, 0,    8'h00, 5'd9, 32'h20);
        addRow("lui",      encI(6'h0F, 5'd0, 5'd3, 16'h1234),   32'h0,        32'h0,        32'h0,        1,   32'h12340000, 1,   5'd3,  32'h12340000, 0, 0, 0,    8'h00, 5'd0, 32'h21);
        addRow("ori",      encI(6'h0D, 5'd1, 5'd3, 16'h8001),   32'h00010000, 32'h0,        32'h0,        1,   32'h00018001, 1,   5'd3,  32'h00018001, 0, 0, 0,    8'h00, 5'd1, 32'h22);
`ifdef SHIFTV_EN
        addRow("sllv",     encR(5'd1, 5'd2, 5'd4, 5'd0, 6'h04), 32'h3,        32'h1,        32'h0,        1,   32'h8,        1,   5'd4,  32'h8,        0, 0, 0,    8'h00, 5'd1, 32'h23);
`else
        addRow("sllv_nop", encR(5'd1, 5'd2, 5'd4, 5'd0, 6'h04), 32'h3,        32'h1,        32'h0,        0,   32'h0,        0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd1, 32'h23);
`endif
        addRow("bne_t",    encI(6'h05, 5'd1, 5'd2, 16'h0010),   32'h3,        32'h4,        32'h0,        1,   32'hFFFFFFFF, 0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd1, 32'h34);
        addRow("sub",      encR(5'd1, 5'd2, 5'd11, 5'd0, 6'h22),32'h3,        32'h5,        32'h0,        1,   32'hFFFFFFFE, 1,   5'd11, 32'hFFFFFFFE, 0, 0, 0,    8'h00, 5'd1, 32'h35);
        addRow("nor",      encR(5'd1, 5'd2, 5'd12, 5'd0, 6'h27),32'h0F0F0000, 32'h000000FF, 32'h0,        1,   32'hF0F0FF00, 1,   5'd12, 32'hF0F0FF00, 0, 0, 0,    8'h00, 5'd1, 32'h36);
        addRow("addu",     encR(5'd1, 5'd2, 5'd13, 5'd0, 6'h21),32'hFFFFFFFF, 32'h2,        32'h0,        1,   32'h1,        1,   5'd13, 32'h1,        0, 0, 0,    8'h00, 5'd1, 32'h37);
        addRow("j",        32'h08000000,                        32'h0,        32'h0,        32'h0,        0,   32'h0,        0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd0, 32'h0);
        addRow("nop3",     NOP,                                 32'h0,        32'h0,        32'h0,        0,   32'h0,        0,   5'd0,  32'h0,        0, 0, 0,    8'h00, 5'd0, 32'h1);

        while (stimQ.size() > 0) begin
            r = stimQ.pop_front();
            applyStimulus(r);
            #3;
            compareRecord();
        end

        // Reset from a non-zero PC must return to PC_RESET.
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset2.pc", pc, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
